mmio_ctrl: RTL and testbench

//  Memory-mapped I/O controller for the 151 core. It decodes EX-stage loads and stores in the 0x8000_00xx window.
//  It sequences the UART TX/RX ready/valid handshakes and buffers received bytes.
//  It holds the cycle and retired-instruction counters.

---
 rtl/mmio_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_mmio_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O block for the 151 core.
// Decodes EX-stage loads/stores in the MMIO_BASE[31:8] window, drives the UART
// TX handshake, buffers received UART bytes and keeps cycle/instret counters.
// Load data and the window-hit flag are registered so they line up with the
// synchronous dmem/bios reads in the WB mux.
// Build option: define MMIO_RX_FIFO_EN to replace the single-entry RX holding
// register with a 2**RX_FIFO_AW-entry circular FIFO.
module mmio_ctrl #(
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int          RX_FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retire,
    output logic        hit,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RX     = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Address decode
    logic        in_win_s;
    logic [7:0]  off_s;
    logic        rd_s;
    logic        wr_s;
    logic        tx_wr_s;
    logic        clr_s;
    logic        rx_rd_s;

    assign in_win_s = (addr[31:8] == MMIO_BASE[31:8]);
    assign off_s    = addr[7:0];
    assign rd_s     = re && in_win_s;
    assign wr_s     = we && in_win_s;
    assign tx_wr_s  = wr_s && (off_s == OFF_TX);
    assign clr_s    = wr_s && (off_s == OFF_CLEAR);
    assign rx_rd_s  = rd_s && (off_s == OFF_RX);

    // TX state and registered handshake outputs
    tx_state_t   tx_state_r;
    logic        tx_valid_r;
    logic [7:0]  tx_data_r;

    // RX storage view shared by both build variants
    logic        rx_full_s;
    logic        rx_empty_s;
    logic [7:0]  rx_head_s;
    logic        rx_push_s;
    logic        rx_pop_s;
    logic        unused_s;

    // Counters
    logic [31:0] cycle_cnt_r;
    logic [31:0] inst_cnt_r;

    // Read path
    logic [31:0] rd_val_s;
    logic [31:0] rdata_r;
    logic        hit_r;

    // A push needs ready (= not full) as seen at the start of the cycle; a pop
    // only happens when there is something to pop, so an empty read is inert.
    assign rx_push_s     = uart_rx_valid && !rx_full_s;
    assign rx_pop_s      = rx_rd_s && !rx_empty_s;
    assign uart_rx_ready = !rx_full_s;

    // TX FSM: accept a byte only when idle, hold it until the receiver takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (tx_wr_s) begin
                        tx_data_r  <= wdata[7:0];
                        tx_valid_r <= 1'b1;
                        tx_state_r <= TX_SEND;
                    end else begin
                        tx_valid_r <= 1'b0;
                        tx_state_r <= TX_IDLE;
                    end
                end
                TX_SEND: begin
                    // Writes seen here are dropped; software polls tx_idle.
                    if (tx_valid_r && uart_tx_ready) begin
                        tx_valid_r <= 1'b0;
                        tx_state_r <= TX_IDLE;
                    end else begin
                        tx_valid_r <= 1'b1;
                        tx_state_r <= TX_SEND;
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    assign uart_tx_valid = tx_valid_r;
    assign uart_tx_data  = tx_data_r;

`ifdef MMIO_RX_FIFO_EN
    localparam int RX_DEPTH = 1 << RX_FIFO_AW;

    logic [7:0]            rx_mem_r [RX_DEPTH];
    logic [RX_FIFO_AW:0]   rx_wptr_r;
    logic [RX_FIFO_AW:0]   rx_rptr_r;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign rx_full_s  = (rx_wptr_r[RX_FIFO_AW] != rx_rptr_r[RX_FIFO_AW]) &&
                        (rx_wptr_r[RX_FIFO_AW-1:0] == rx_rptr_r[RX_FIFO_AW-1:0]);
    assign rx_empty_s = (rx_wptr_r == rx_rptr_r);
    assign rx_head_s  = rx_mem_r[rx_rptr_r[RX_FIFO_AW-1:0]];
    assign unused_s   = ^wdata[31:8];

    // RX FIFO pointers; reset empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr_r <= '0;
            rx_rptr_r <= '0;
        end else begin
            if (rx_push_s) begin
                rx_wptr_r <= rx_wptr_r + (RX_FIFO_AW+1)'(1);
            end else begin
                rx_wptr_r <= rx_wptr_r;
            end
            if (rx_pop_s) begin
                rx_rptr_r <= rx_rptr_r + (RX_FIFO_AW+1)'(1);
            end else begin
                rx_rptr_r <= rx_rptr_r;
            end
        end
    end

    // RX FIFO storage; contents are meaningless while the pointers say empty
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wptr_r[RX_FIFO_AW-1:0]] <= uart_rx_data;
        end
    end
`else
    logic [7:0] rx_hold_r;
    logic       rx_hold_vld_r;

    assign rx_full_s  = rx_hold_vld_r;
    assign rx_empty_s = !rx_hold_vld_r;
    assign rx_head_s  = rx_hold_r;
    assign unused_s   = ^{wdata[31:8], (RX_FIFO_AW > 0)};

    // Single-entry RX holding register; push and pop are mutually exclusive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hold_r     <= 8'h00;
            rx_hold_vld_r <= 1'b0;
        end else if (rx_push_s) begin
            rx_hold_r     <= uart_rx_data;
            rx_hold_vld_r <= 1'b1;
        end else if (rx_pop_s) begin
            rx_hold_vld_r <= 1'b0;
        end else begin
            rx_hold_vld_r <= rx_hold_vld_r;
        end
    end
`endif

    // Cycle and retired-instruction counters; a clear beats an increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_r <= 32'h0000_0000;
            inst_cnt_r  <= 32'h0000_0000;
        end else if (clr_s) begin
            cycle_cnt_r <= 32'h0000_0000;
            inst_cnt_r  <= 32'h0000_0000;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if (inst_retire) begin
                inst_cnt_r <= inst_cnt_r + 32'd1;
            end else begin
                inst_cnt_r <= inst_cnt_r;
            end
        end
    end

    // Load mux built from pre-update state so re+we returns the old value
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (off_s)
            OFF_STATUS: rd_val_s = {30'b0, !rx_empty_s, (tx_state_r == TX_IDLE)};
            OFF_RX: begin
                if (rx_empty_s) begin
                    rd_val_s = 32'h0000_0000;
                end else begin
                    rd_val_s = {24'h00_0000, rx_head_s};
                end
            end
            OFF_CYCLE:  rd_val_s = cycle_cnt_r;
            OFF_INST:   rd_val_s = inst_cnt_r;
            default:    rd_val_s = 32'h0000_0000;
        endcase
    end

    // Register load data and window hit for the WB-stage mux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
            hit_r   <= 1'b0;
        end else begin
            hit_r <= (re || we) && in_win_s;
            if (rd_s) begin
                rdata_r <= rd_val_s;
            end else begin
                rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign rdata = rdata_r;
    assign hit   = hit_r;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed self-checking bench for mmio_ctrl. Inputs are driven 1 time unit
// after each rising edge and outputs are checked at that same point.
module tb_mmio_ctrl;

    localparam logic [31:0] B = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retire;
    logic        hit;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int n_assert = 0;
    int n_fail   = 0;

    mmio_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .inst_retire   (inst_retire),
        .hit           (hit),
        .rdata         (rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        addr = a;
        re   = 1'b1;
        step();
        re   = 1'b0;
        d    = rdata;
        h    = hit;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        addr  = a;
        wdata = v;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        for (int k = 0; k < 20; k++) begin
            if (uart_rx_ready) break;
            step();
        end
        chk("push_ready", {31'b0, uart_rx_ready}, 32'h1);
        step();
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] d2;
        logic        h;
        int          xfers;

        rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0;
        inst_retire = 1'b0; uart_tx_ready = 1'b0;
        uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

        // ---- 1) reset ----
        step(); step();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_hit", {31'b0, hit}, 32'h0);
        chk("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
        chk("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
        rst = 1'b0;
        rd(B + 32'h00, d, h);
        chk("status_after_rst", d, 32'h1);
        chk("hit_status", {31'b0, h}, 32'h1);
        addr = B + 32'h10; re = 1'b1;
        step(); d = rdata;
        step(); d2 = rdata;
        re = 1'b0;
        chk("cycle_delta", d2 - d, 32'h1);
        // reset in the middle of a send with a byte buffered
        push(8'h77);
        wr(B + 32'h08, 32'h41);
        chk("tx_valid_pre_rst", {31'b0, uart_tx_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("tx_valid_async_rst", {31'b0, uart_tx_valid}, 32'h0);
        chk("rx_ready_async_rst", {31'b0, uart_rx_ready}, 32'h1);
        step();
        rst = 1'b0;
        rd(B + 32'h00, d, h);
        chk("status_after_mid_rst", d, 32'h1);

        // ---- 2) TX handshake ----
        uart_tx_ready = 1'b0;
        wr(B + 32'h08, 32'hAB41);
        for (int i = 0; i < 5; i++) begin
            chk("tx_hold_valid", {31'b0, uart_tx_valid}, 32'h1);
            chk("tx_hold_data", {24'b0, uart_tx_data}, 32'h41);
            step();
        end
        wr(B + 32'h08, 32'h42);
        chk("tx_drop_data", {24'b0, uart_tx_data}, 32'h41);
        rd(B + 32'h00, d, h);
        chk("status_sending", d, 32'h0);
        uart_tx_ready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 3; i++) begin
            if (uart_tx_valid) xfers++;
            step();
        end
        uart_tx_ready = 1'b0;
        chk("tx_one_transfer", xfers, 32'h1);
        chk("tx_valid_done", {31'b0, uart_tx_valid}, 32'h0);
        rd(B + 32'h00, d, h);
        chk("status_tx_done", d, 32'h1);

        // ---- 3) RX buffer ----
        push(8'h11);
        rd(B + 32'h00, d, h);
        chk("status_rx_avail", d, 32'h3);
        rd(32'h1000_0004, d, h);
        chk("outside_rx_rdata", d, 32'h0);
        chk("outside_rx_hit", {31'b0, h}, 32'h0);
        rd(B + 32'h00, d, h);
        chk("status_no_side_effect", d, 32'h3);
        rd(B + 32'h04, d, h);
        chk("rx_first", d, 32'h11);
        push(8'h22);
        rd(B + 32'h04, d, h);
        chk("rx_second", d, 32'h22);
        rd(B + 32'h00, d, h);
        chk("status_rx_drained", d, 32'h1);
        rd(B + 32'h04, d, h);
        chk("rx_empty_read", d, 32'h0);
        rd(B + 32'h00, d, h);
        chk("status_after_empty_read", d, 32'h1);
        // push and pop together while empty: read 0, byte kept
        uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
        rd(B + 32'h04, d, h);
        uart_rx_valid = 1'b0;
        chk("rx_empty_pushpop", d, 32'h0);
        rd(B + 32'h04, d, h);
        chk("rx_kept_byte", d, 32'h33);

        // ---- 4) RX full ----
`ifdef MMIO_RX_FIFO_EN
        for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
        chk("fifo_full_ready", {31'b0, uart_rx_ready}, 32'h0);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fifo_held_off", {31'b0, uart_rx_ready}, 32'h0);
        end
        rd(B + 32'h04, d, h);
        chk("fifo_pop_full", d, 32'h80);
        chk("fifo_ready_after_pop", {31'b0, uart_rx_ready}, 32'h1);
        step();
        uart_rx_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            rd(B + 32'h04, d, h);
            chk("fifo_order", d, 32'h80 + i);
        end
        rd(B + 32'h04, d, h);
        chk("fifo_ninth", d, 32'h99);
`else
        push(8'h55);
        chk("hold_full_ready", {31'b0, uart_rx_ready}, 32'h0);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_held_off", {31'b0, uart_rx_ready}, 32'h0);
        end
        rd(B + 32'h04, d, h);
        chk("hold_pop_full", d, 32'h55);
        chk("hold_ready_after_pop", {31'b0, uart_rx_ready}, 32'h1);
        step();
        uart_rx_valid = 1'b0;
        rd(B + 32'h04, d, h);
        chk("hold_second", d, 32'h66);
`endif
        rd(B + 32'h00, d, h);
        chk("status_rx_final", d, 32'h1);

        // ---- 5) counters ----
        wr(B + 32'h18, 32'h0);
        rd(B + 32'h10, d, h);
        chk("cycle_after_clear", d, 32'h0);
        @(negedge clk);
        force dut.cycle_cnt_r = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt_r;
        step();
        chk("cycle_wrap", dut.cycle_cnt_r, 32'h0);
        wr(B + 32'h18, 32'h0);
        inst_retire = 1'b1;
        step(); step(); step();
        inst_retire = 1'b0;
        rd(B + 32'h14, d, h);
        chk("inst_three", d, 32'h3);
        inst_retire = 1'b1;
        wr(B + 32'h18, 32'h0);
        inst_retire = 1'b0;
        rd(B + 32'h14, d, h);
        chk("inst_clear_wins", d, 32'h0);

        // ---- 6) decode ----
        rd(32'h1000_0010, d, h);
        chk("outside_rdata", d, 32'h0);
        chk("outside_hit", {31'b0, h}, 32'h0);
        rd(B + 32'h0C, d, h);
        chk("unmapped_rdata", d, 32'h0);
        chk("unmapped_hit", {31'b0, h}, 32'h1);
        rd(B + 32'h08, d, h);
        chk("writeonly_rdata", d, 32'h0);
        inst_retire = 1'b1;
        step(); step();
        inst_retire = 1'b0;
        addr = B + 32'h18; re = 1'b1; we = 1'b1;
        step();
        re = 1'b0; we = 1'b0;
        chk("rw_clear_rdata", rdata, 32'h0);
        chk("rw_clear_hit", {31'b0, hit}, 32'h1);
        rd(B + 32'h14, d, h);
        chk("rw_inst_cleared", d, 32'h0);
        rd(B + 32'h10, d, h);
        chk("rw_cycle_cleared", d, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
